// File: rtl/lr_infer_ctrl_if.sv
// Bus bundle for lr_infer_ctrl: parameter/feature RAM read port and the
// labelled-result valid/ready port. The controller uses the master view,
// RAMs and the result consumer use the slave view.
interface lr_infer_ctrl_if #(
    parameter int unsigned DW  = 16,
    parameter int unsigned AW  = 5,
    parameter int unsigned XAW = 9,
    parameter int unsigned SW  = 4
);
    // RAM read side (sync read, data valid the cycle after rd_en)
    logic           rd_en;
    logic [AW-1:0]  w_addr;
    logic [XAW-1:0] x_addr;
    logic [DW-1:0]  w_data;
    logic [DW-1:0]  x_data;

    // result side
    logic           res_valid;
    logic           res_ready;
    logic           res_ypred;
    logic [11:0]    res_prob;
    logic [SW-1:0]  res_idx;

    modport master (
        output rd_en, w_addr, x_addr,
        input  w_data, x_data,
        output res_valid, res_ypred, res_prob, res_idx,
        input  res_ready
    );

    modport slave (
        input  rd_en, w_addr, x_addr,
        output w_data, x_data,
        input  res_valid, res_ypred, res_prob, res_idx,
        output res_ready
    );
endinterface

// File: rtl/lr_infer_ctrl.sv
// Logistic-regression inference sequencer. For each sample of a batch it
// streams N_FEAT weight/feature pairs out of the RAMs, accumulates their
// sign-magnitude products, adds the bias, maps the sum through a 12-level
// piecewise sigmoid and presents one labelled result on a valid/ready port.
module lr_infer_ctrl #(
    parameter int unsigned          N_FEAT = 30,
    parameter int unsigned          DW     = 16,
    parameter int unsigned          AW     = 5,
    parameter int unsigned          SW     = 4,
    parameter int unsigned          XAW    = 9,
    parameter int unsigned          ACC_W  = 40,
    parameter logic signed [DW-1:0] BIAS   = 16'sd434
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SW-1:0]   n_samples,
    output logic            busy,
    output logic            done,
    lr_infer_ctrl_if.master bus
);
    localparam int unsigned PW = 2 * (DW - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_BIAS,
        S_ACT,
        S_OUT,
        S_FIN
    } state_t;

    state_t                  state;
    logic [AW-1:0]           i;
    logic [SW-1:0]           s;
    logic [SW-1:0]           n_lat;
    logic [XAW-1:0]          x_base;
    logic                    rd_en_d;
    logic signed [ACC_W-1:0] acc;

    logic [PW-1:0]           prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic                    neg_term;
    logic                    last_feat;
    logic                    last_sample;
    logic [XAW-1:0]          next_base;
    logic [11:0]             prob_next;

    function automatic logic signed [ACC_W-1:0] thr(input int v);
        return ACC_W'(v);
    endfunction

    // Piecewise sigmoid on the full-width accumulator, half-open intervals [lo,hi)
    function automatic logic [11:0] sigmoid12(input logic signed [ACC_W-1:0] a);
        if      (a < thr(-12288)) return 12'd41;
        else if (a < thr(-8192))  return 12'd205;
        else if (a < thr(-6963))  return 12'd614;
        else if (a < thr(-5325))  return 12'd819;
        else if (a < thr(-3277))  return 12'd1229;
        else if (a < thr(-1638))  return 12'd1638;
        else if (a < thr(410))    return 12'd2048;
        else if (a < thr(2048))   return 12'd2458;
        else if (a < thr(3686))   return 12'd2867;
        else if (a < thr(5734))   return 12'd3277;
        else if (a < thr(7373))   return 12'd3482;
        else                      return 12'd3686;
    endfunction

    assign bus.w_addr = i;

    // Magnitude product, sign decision, bias extension and sigmoid lookup
    always_comb begin
        prod        = {{(DW-1){1'b0}}, bus.w_data[DW-2:0]} *
                      {{(DW-1){1'b0}}, bus.x_data[DW-2:0]};
        prod_ext    = {{(ACC_W-PW){1'b0}}, prod};
        neg_term    = bus.w_data[DW-1] ^ bus.x_data[DW-1];
        bias_ext    = {{(ACC_W-DW){BIAS[DW-1]}}, BIAS};
        last_feat   = (i == AW'(N_FEAT - 1));
        last_sample = (s == n_lat - SW'(1));
        next_base   = x_base + XAW'(N_FEAT);
        prob_next   = sigmoid12(acc);
    end

    // Sequencer FSM with registered outputs; the MAC runs one cycle behind rd_en
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.rd_en     <= 1'b0;
            bus.x_addr    <= '0;
            bus.res_valid <= 1'b0;
            bus.res_ypred <= 1'b0;
            bus.res_prob  <= '0;
            bus.res_idx   <= '0;
            i             <= '0;
            s             <= '0;
            n_lat         <= '0;
            x_base        <= '0;
            rd_en_d       <= 1'b0;
            acc           <= '0;
        end else begin
            done    <= 1'b0;
            rd_en_d <= bus.rd_en;
            // data returned for the previous read strobe; -0 gives a zero product
            if (rd_en_d) begin
                if (neg_term) acc <= acc - prod_ext;
                else          acc <= acc + prod_ext;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_lat  <= n_samples;
                        s      <= '0;
                        i      <= '0;
                        acc    <= '0;
                        x_base <= '0;
                        if (n_samples != '0) begin
                            state      <= S_FETCH;
                            busy       <= 1'b1;
                            bus.rd_en  <= 1'b1;
                            bus.x_addr <= '0;
                        end else begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end
                    end
                end

                S_FETCH: begin
                    if (last_feat) begin
                        state     <= S_DRAIN;
                        bus.rd_en <= 1'b0;
                    end else begin
                        i          <= i + AW'(1);
                        bus.x_addr <= bus.x_addr + XAW'(1);
                    end
                end

                S_DRAIN: state <= S_BIAS;

                S_BIAS: begin
                    acc   <= acc + bias_ext;
                    state <= S_ACT;
                end

                S_ACT: begin
                    bus.res_prob  <= prob_next;
                    bus.res_ypred <= (prob_next > 12'd2048);
                    bus.res_idx   <= s;
                    bus.res_valid <= 1'b1;
                    state         <= S_OUT;
                end

                S_OUT: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        if (!last_sample) begin
                            s          <= s + SW'(1);
                            i          <= '0;
                            acc        <= '0;
                            x_base     <= next_base;
                            bus.x_addr <= next_base;
                            bus.rd_en  <= 1'b1;
                            state      <= S_FETCH;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end

                S_FIN: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lr_infer_ctrl.sv
// Self-checking bench for lr_infer_ctrl: RAM models, a cycle-level
// behavioural reference of the batch protocol, directed corner cases
// and randomized batches with random backpressure.
module tb_lr_infer_ctrl;
    localparam int NF = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] n_samples;
    logic       busy;
    logic       done;

    lr_infer_ctrl_if #(.DW(16), .AW(5), .XAW(9), .SW(4)) bus ();

    lr_infer_ctrl #(
        .N_FEAT(30), .DW(16), .AW(5), .SW(4), .XAW(9), .ACC_W(40), .BIAS(16'sd434)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [15:0] wmem [0:31];
    logic [15:0] xmem [0:511];

    // Synchronous-read RAMs, one cycle latency
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.w_data <= wmem[bus.w_addr];
            bus.x_data <= xmem[bus.x_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sm(input logic [15:0] v);
        longint m;
        m = longint'(v[14:0]);
        return v[15] ? -m : m;
    endfunction

    function automatic int model_prob(input longint a);
        if (a >= 7373)        return 3686;
        else if (a >= 5734)   return 3482;
        else if (a >= 3686)   return 3277;
        else if (a >= 2048)   return 2867;
        else if (a >= 410)    return 2458;
        else if (a >= -1638)  return 2048;
        else if (a >= -3277)  return 1638;
        else if (a >= -5325)  return 1229;
        else if (a >= -6963)  return 819;
        else if (a >= -8192)  return 614;
        else if (a >= -12288) return 205;
        else                  return 41;
    endfunction

    int exp_prob [0:15];

    task automatic compute_batch(input int n);
        for (int s = 0; s < n; s++) begin
            longint a;
            a = 434;
            for (int i = 0; i < NF; i++) a += sm(wmem[i]) * sm(xmem[s*NF + i]);
            exp_prob[s] = model_prob(a);
        end
    endtask

    // reference model state: predicted DUT state after the latest clock edge
    bit  cmp_en = 1'b0;
    bit  m_active = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    bit  m_valid, m_rd, prev_done;
    int  m_n = 0, m_s = 0, m_t = 0;
    int  hs_count = 0, done_cnt = 0, stall_cnt = 0;
    int  last_prob = 0, last_ypred = 0, last_idx = 0;
    int  rcv_idx [$];

    // Compare DUT against the model each cycle, then advance the model
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            m_valid = m_active && (m_t >= NF + 3);
            m_rd    = m_active && (m_t < NF);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("res_valid", bus.res_valid, m_valid);
            check("rd_en", bus.rd_en, m_rd);
            if (done) done_cnt++;
            if (m_rd) begin
                check("w_addr", bus.w_addr, m_t);
                check("x_addr", bus.x_addr, m_s*NF + m_t);
            end
            if (m_valid) begin
                check("res_prob", bus.res_prob, exp_prob[m_s]);
                check("res_ypred", bus.res_ypred, (exp_prob[m_s] > 2048) ? 1 : 0);
                check("res_idx", bus.res_idx, m_s);
                if (bus.res_ready) begin
                    hs_count++;
                    rcv_idx.push_back(int'(bus.res_idx));
                    last_prob  = int'(bus.res_prob);
                    last_ypred = int'(bus.res_ypred);
                    last_idx   = int'(bus.res_idx);
                end else begin
                    stall_cnt++;
                end
            end
            if (rst) begin
                m_active = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            end else begin
                prev_done = m_done;
                m_done    = 1'b0;
                if (m_active) begin
                    if (m_valid && bus.res_ready) begin
                        if (m_s == m_n - 1) begin
                            m_active = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                        end else begin
                            m_s++; m_t = 0;
                        end
                    end else if (!m_valid) begin
                        m_t++;
                    end
                end else if (!prev_done && start) begin
                    m_s = 0; m_t = 0; m_n = int'(n_samples);
                    if (m_n > 0) begin
                        m_active = 1'b1; m_busy = 1'b1;
                        compute_batch(m_n);
                    end else begin
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    // Result consumer: 0 always ready, 1 random, 2 hold off idx 1 for stall_left cycles
    int ready_mode = 0;
    int stall_left = 0;
    initial begin
        bus.res_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: bus.res_ready = 1'b1;
                1: bus.res_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (bus.res_valid && bus.res_idx == 4'd1 && stall_left > 0) begin
                        bus.res_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.res_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic fill_mem(input int mode);
        for (int k = 0; k < 32; k++)
            wmem[k] = (mode == 0) ? 16'h0000 : {1'($urandom_range(0, 1)), 11'd0, 4'($urandom_range(0, 15))};
        for (int k = 0; k < 512; k++)
            xmem[k] = (mode == 0) ? 16'h0000 : {1'($urandom_range(0, 1)), 7'd0, 8'($urandom_range(0, 200))};
    endtask

    task automatic start_batch(input int n);
        n_samples = 4'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((m_active || m_done || busy) && k < 3000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 3000) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, k);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    int hs0, dn0, lat;

    initial begin
        rst = 1'b1; start = 1'b0; n_samples = '0;
        fill_mem(0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_rd_en", bus.rd_en, 0);
        check("reset_valid", bus.res_valid, 0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // hand-computed sigmoid points that pin the reference table
        check("pin_434", model_prob(434), 2458);
        check("pin_m566", model_prob(-566), 2048);
        check("pin_m12288", model_prob(-12288), 205);
        check("pin_m12289", model_prob(-12289), 41);
        check("pin_2047", model_prob(2047), 2458);
        check("pin_2048", model_prob(2048), 2867);
        check("pin_max", model_prob(64'sd32210288670 + 434), 3686);

        // T1: all zero, n=1 -> bias only; res_valid 33 edges after the start edge
        dn0 = done_cnt; hs0 = hs_count;
        start_batch(1);
        lat = 0;
        while (!bus.res_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t1_latency", lat, 33);
        wait_idle("t1");
        check("t1_prob", last_prob, 2458);
        check("t1_ypred", last_ypred, 1);
        check("t1_idx", last_idx, 0);
        check("t1_done_count", done_cnt - dn0, 1);
        check("t1_results", hs_count - hs0, 1);

        // T2: single negative feature -> acc=-566
        wmem[0] = 16'h0001; xmem[0] = 16'h83E8;
        start_batch(1); wait_idle("t2");
        check("t2_prob", last_prob, 2048);
        check("t2_ypred", last_ypred, 0);

        // T3: exact lower boundary -12288
        xmem[0] = 16'hB1B2;
        start_batch(1); wait_idle("t3");
        check("t3_prob", last_prob, 205);
        check("t3_ypred", last_ypred, 0);

        // T4: full-scale magnitudes, both signs, no wrap
        for (int k = 0; k < NF; k++) begin wmem[k] = 16'h7FFF; xmem[k] = 16'h7FFF; end
        start_batch(1); wait_idle("t4a");
        check("t4_prob_pos", last_prob, 3686);
        check("t4_ypred_pos", last_ypred, 1);
        for (int k = 0; k < NF; k++) wmem[k] = 16'hFFFF;
        start_batch(1); wait_idle("t4b");
        check("t4_prob_neg", last_prob, 41);

        // empty batch: one done, no results
        dn0 = done_cnt; hs0 = hs_count;
        start_batch(0); wait_idle("n0");
        check("n0_done_count", done_cnt - dn0, 1);
        check("n0_results", hs_count - hs0, 0);

        // T5: n=3 with a 5-cycle stall on idx 1
        fill_mem(1);
        rcv_idx.delete();
        dn0 = done_cnt; hs0 = hs_count; stall_cnt = 0;
        ready_mode = 2; stall_left = 5;
        start_batch(3); wait_idle("t5");
        check("t5_results", hs_count - hs0, 3);
        check("t5_stall_cycles", stall_cnt, 5);
        check("t5_done_count", done_cnt - dn0, 1);
        check("t5_nrcv", rcv_idx.size(), 3);
        for (int k = 0; k < rcv_idx.size(); k++) check("t5_order", rcv_idx[k], k);
        ready_mode = 0;

        // T6: reset at FETCH i=10 aborts, then a fresh batch ignores a mid-batch start
        dn0 = done_cnt; hs0 = hs_count;
        start_batch(2);
        lat = 0;
        while (!(bus.rd_en && bus.w_addr == 5'd10) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t6_reach_i10", (lat < 50) ? 1 : 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_rd_en", bus.rd_en, 0);
        check("t6_valid", bus.res_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_done", done_cnt - dn0, 0);
        check("t6_no_result", hs_count - hs0, 0);
        start_batch(2);
        repeat (5) @(posedge clk);
        #1;
        start_batch(7);
        n_samples = 4'd12;
        wait_idle("t6b");
        check("t6_results", hs_count - hs0, 2);
        check("t6_done_count", done_cnt - dn0, 1);

        // randomized batches under random backpressure
        ready_mode = 1;
        for (int b = 0; b < 6; b++) begin
            int n;
            fill_mem(1);
            n = (b == 2) ? 0 : int'($urandom_range(1, 15));
            hs0 = hs_count; dn0 = done_cnt;
            start_batch(n);
            wait_idle("rand");
            check("rand_results", hs_count - hs0, n);
            check("rand_done_count", done_cnt - dn0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule
